por_reset_ctrl: RTL and testbench
=================================

POR_RESET_CTRL -- requirements
Module: por_reset_ctrl

Interface
REQ-001 SHALL have parameter OST_CYCLES, default 1024, oscillator start-up count in clk cycles (minimum 2).
REQ-002 SHALL have parameter PWRT_CYCLES, default 256, power-up timer count in clk cycles (minimum 2).
REQ-003 SHALL have parameter WDT_CYCLES, default 4096, watchdog period in clk cycles (minimum 4).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high external reset (MCLR equivalent).
REQ-006 SHALL have port wdt_en, input, 1 bit: enables the watchdog counter.
REQ-007 SHALL have port clrwdt, input, 1 bit: single-cycle pulse, CLRWDT instruction executed.
REQ-008 SHALL have port sleep, input, 1 bit: single-cycle pulse, SLEEP instruction executed.
REQ-009 SHALL have port wake, input, 1 bit: level, external or interrupt wake request.
REQ-010 SHALL have port core_rst, output, 1 bit: active-high reset to the core.
REQ-011 SHALL have port core_run, output, 1 bit: core clock enable.
REQ-012 SHALL have port to_n, output, 1 bit: STATUS time-out bit.
REQ-013 SHALL have port pd_n, output, 1 bit: STATUS power-down bit.
REQ-014 SHALL have port rst_cause, output, 2 bits: 00 external reset, 01 WDT reset, 10 WDT wake, 11 pin wake.

Function
REQ-015 SHALL release reset internally through a 2-flop synchronizer: asserted asynchronously, deasserted on the 2nd rising edge of clk after reset falls.
REQ-016 SHALL implement the states RST, OST, PWRT, RUN, SLEEP and WDTRST.
REQ-017 SHALL transition RST->OST on synchronized release, OST->PWRT after OST_CYCLES, and PWRT->RUN after PWRT_CYCLES.
REQ-018 SHALL drop core_rst on the edge that enters RUN, i.e. 2+OST_CYCLES+PWRT_CYCLES cycles after reset falls.
REQ-019 SHALL drive core_run=1 only in RUN and core_rst=1 in RST, OST, PWRT and WDTRST.
REQ-020 SHALL run the watchdog counter only while wdt_en=1 in RUN or SLEEP, and hold it at 0 in all other states.
REQ-021 SHALL have the watchdog expire when the counter reaches WDT_CYCLES-1 with no clear in that cycle.
REQ-022 SHALL clear the watchdog and set to_n=1, pd_n=1 on clrwdt in RUN.
REQ-023 SHALL, on sleep in RUN: clear the watchdog, set to_n=1 and pd_n=0, and go to SLEEP on the next edge.
REQ-024 SHALL give clrwdt priority over a simultaneous expiry, and sleep priority over both clrwdt and expiry.
REQ-025 SHALL, on expiry in RUN: go to WDTRST, set to_n=0 and rst_cause=01, hold WDTRST 1 cycle, then PWRT, then RUN.
REQ-026 SHALL, on expiry in SLEEP: set to_n=0 and rst_cause=10, and go to OST with core_rst held 0.
REQ-027 SHALL, on wake=1 in SLEEP (wake wins over a same-cycle expiry): set rst_cause=11 and go to OST with core_rst held 0.
REQ-028 SHALL, in OST entered from SLEEP, go to RUN after OST_CYCLES, skipping PWRT.
REQ-029 SHALL ignore sleep, clrwdt and wake in all states other than those stated.
REQ-030 SHALL size the counters to $clog2 of the largest parameter; the counters SHALL wrap to 0 on every state change.

Reset
REQ-031 SHALL, while reset=1 (asynchronously, in any state including mid-OST/PWRT/SLEEP): state=RST, core_rst=1, core_run=0, to_n=1, pd_n=1, rst_cause=00, all counters 0.

Structure
REQ-032 SHALL place the state encoding typedef and the rst_cause codes in shared package pic_reset_pkg.
REQ-033 SHALL implement the synchronizer as sub-module reset_sync (2 flops, async assert, sync deassert).

Verification (OST_CYCLES=8, PWRT_CYCLES=4, WDT_CYCLES=16)
REQ-034 SHALL check: reset held 4 cycles, then released -> core_rst falls exactly 14 cycles later; to_n=1, pd_n=1, rst_cause=00.
REQ-035 SHALL check: wdt_en=1 in RUN with no clrwdt -> at cycle 16 in RUN, core_rst=1 for 1 cycle, then 4 cycles of PWRT, then RUN; to_n=0, rst_cause=01.
REQ-036 SHALL check: clrwdt every 10 cycles for 100 cycles -> no expiry, to_n stays 1.
REQ-037 SHALL check: sleep pulse -> pd_n=0 and core_run=0; wake at +5 -> core_run=1 after 8 OST cycles, core_rst stays 0, rst_cause=11.
REQ-038 SHALL check: sleep with wdt_en=1 and no wake -> expiry after 16 cycles, to_n=0, rst_cause=10, RUN after 8 more cycles.
REQ-039 SHALL check: reset asserted mid-PWRT and mid-SLEEP -> outputs equal their reset values in the same timestep, without waiting for a clk edge.

Source files
------------

// File: rtl/pic_reset_pkg.sv
// rtl/pic_reset_pkg.sv - shared state encoding and reset-cause codes for the POR/WDT reset controller
package pic_reset_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_OST    = 3'd1,
    ST_PWRT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SLEEP  = 3'd4,
    ST_WDTRST = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_EXT      = 2'b00;
  localparam logic [1:0] CAUSE_WDT_RST  = 2'b01;
  localparam logic [1:0] CAUSE_WDT_WAKE = 2'b10;
  localparam logic [1:0] CAUSE_PIN_WAKE = 2'b11;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - two-flop reset synchronizer, asynchronous assert, synchronous release
module reset_sync (
  input  logic clk,
  input  logic arst,
  output logic release_next
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], 1'b0};
  end

  // High in the cycle whose closing edge deasserts the synchronized reset.
  assign release_next = sync_q[1] & ~sync_q[0];

endmodule

// File: rtl/por_reset_ctrl.sv
// rtl/por_reset_ctrl.sv - power-on/oscillator/watchdog reset sequencer with sleep and wake handling
module por_reset_ctrl #(
  parameter int OST_CYCLES  = 1024,
  parameter int PWRT_CYCLES = 256,
  parameter int WDT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wdt_en,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       wake,
  output logic       core_rst,
  output logic       core_run,
  output logic       to_n,
  output logic       pd_n,
  output logic [1:0] rst_cause
);
  import pic_reset_pkg::*;

  localparam int CW = cnt_width(OST_CYCLES, PWRT_CYCLES, WDT_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] OST_LAST  = CW'(OST_CYCLES - 1);
  localparam logic [CW-1:0] PWRT_LAST = CW'(PWRT_CYCLES - 1);
  localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   st_cnt_q, st_cnt_d;
  logic [CW-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic            to_n_q, to_n_d;
  logic            pd_n_q, pd_n_d;
  logic [1:0]      cause_q, cause_d;
  logic            from_sleep_q, from_sleep_d;
  logic            release_next;
  logic            wdt_active;
  logic            wdt_hit;

  reset_sync u_reset_sync (
    .clk          (clk),
    .arst         (reset),
    .release_next (release_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RST;
      st_cnt_q     <= '0;
      wdt_cnt_q    <= '0;
      to_n_q       <= 1'b1;
      pd_n_q       <= 1'b1;
      cause_q      <= CAUSE_EXT;
      from_sleep_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_cnt_q     <= st_cnt_d;
      wdt_cnt_q    <= wdt_cnt_d;
      to_n_q       <= to_n_d;
      pd_n_q       <= pd_n_d;
      cause_q      <= cause_d;
      from_sleep_q <= from_sleep_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    st_cnt_d     = '0;
    wdt_cnt_d    = wdt_cnt_q;
    to_n_d       = to_n_q;
    pd_n_d       = pd_n_q;
    cause_d      = cause_q;
    from_sleep_d = from_sleep_q;
    wdt_active   = wdt_en && (state_q == ST_RUN || state_q == ST_SLEEP);
    wdt_hit      = wdt_active && (wdt_cnt_q == WDT_LAST);
    if (wdt_active) wdt_cnt_d = wdt_cnt_q + ONE;

    case (state_q)
      ST_RST: begin
        if (release_next) state_d = ST_OST;
      end
      ST_OST: begin
        st_cnt_d = st_cnt_q + ONE;
        if (st_cnt_q == OST_LAST) begin
          state_d      = from_sleep_q ? ST_RUN : ST_PWRT;
          from_sleep_d = 1'b0;
        end
      end
      ST_PWRT: begin
        st_cnt_d = st_cnt_q + ONE;
        if (st_cnt_q == PWRT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // sleep outranks clrwdt, which outranks a same-cycle expiry
        if (sleep) begin
          state_d   = ST_SLEEP;
          wdt_cnt_d = '0;
          to_n_d    = 1'b1;
          pd_n_d    = 1'b0;
        end else if (clrwdt) begin
          wdt_cnt_d = '0;
          to_n_d    = 1'b1;
          pd_n_d    = 1'b1;
        end else if (wdt_hit) begin
          state_d = ST_WDTRST;
          to_n_d  = 1'b0;
          cause_d = CAUSE_WDT_RST;
        end
      end
      ST_SLEEP: begin
        if (wake) begin
          state_d      = ST_OST;
          cause_d      = CAUSE_PIN_WAKE;
          from_sleep_d = 1'b1;
        end else if (wdt_hit) begin
          state_d      = ST_OST;
          to_n_d       = 1'b0;
          cause_d      = CAUSE_WDT_WAKE;
          from_sleep_d = 1'b1;
        end
      end
      ST_WDTRST: begin
        state_d = ST_PWRT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    if (state_d != state_q) begin
      st_cnt_d  = '0;
      wdt_cnt_d = '0;
    end
  end

  // A wake-up oscillator restart keeps the core out of reset.
  assign core_rst  = (state_q == ST_RST) || (state_q == ST_PWRT) || (state_q == ST_WDTRST) ||
                     (state_q == ST_OST && !from_sleep_q);
  assign core_run  = (state_q == ST_RUN);
  assign to_n      = to_n_q;
  assign pd_n      = pd_n_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_por_reset_ctrl.sv
// tb/tb_por_reset_ctrl.sv - self-checking bench for por_reset_ctrl: vector table, corner sequences, random vs reference model
module tb_por_reset_ctrl;

  localparam int OST  = 8;
  localparam int PWRT = 4;
  localparam int WDT  = 16;

  localparam int P_HOLD  = 0;
  localparam int P_OSC   = 1;
  localparam int P_PWR   = 2;
  localparam int P_RUN   = 3;
  localparam int P_SLEEP = 4;
  localparam int P_WDTR  = 5;

  logic       clk;
  logic       reset;
  logic       wdt_en;
  logic       clrwdt;
  logic       sleep;
  logic       wake;
  logic       core_rst;
  logic       core_run;
  logic       to_n;
  logic       pd_n;
  logic [1:0] rst_cause;
  logic [5:0] dut_out;

  int checks;
  int errors;

  int         m_phase;
  int         m_left;
  int         m_wdt;
  int         m_sync;
  bit         m_woke;
  bit         m_to_n;
  bit         m_pd_n;
  logic [1:0] m_cause;

  typedef struct {
    int         n;
    bit         en;
    bit         clr;
    bit         slp;
    bit         wk;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  por_reset_ctrl #(
    .OST_CYCLES  (OST),
    .PWRT_CYCLES (PWRT),
    .WDT_CYCLES  (WDT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wdt_en    (wdt_en),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .wake      (wake),
    .core_rst  (core_rst),
    .core_run  (core_run),
    .to_n      (to_n),
    .pd_n      (pd_n),
    .rst_cause (rst_cause)
  );

  assign dut_out = {core_rst, core_run, to_n, pd_n, rst_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {rst,run,to_n,pd_n,cause}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_HOLD;
    m_left  = 0;
    m_wdt   = 0;
    m_sync  = 0;
    m_woke  = 1'b0;
    m_to_n  = 1'b1;
    m_pd_n  = 1'b1;
    m_cause = 2'b00;
  endtask

  function automatic logic [5:0] model_out();
    bit rst_o;
    rst_o = (m_phase == P_HOLD) || (m_phase == P_PWR) || (m_phase == P_WDTR) ||
            (m_phase == P_OSC && !m_woke);
    return {rst_o, (m_phase == P_RUN), m_to_n, m_pd_n, m_cause};
  endfunction

  task automatic model_step();
    int prev;
    if (reset) begin
      model_reset();
      return;
    end
    prev = m_phase;
    case (m_phase)
      P_HOLD: begin
        m_sync++;
        if (m_sync == 2) begin m_phase = P_OSC; m_left = OST; end
      end
      P_OSC: begin
        m_left--;
        if (m_left == 0) begin
          if (m_woke) m_phase = P_RUN;
          else begin m_phase = P_PWR; m_left = PWRT; end
          m_woke = 1'b0;
        end
      end
      P_PWR: begin
        m_left--;
        if (m_left == 0) m_phase = P_RUN;
      end
      P_WDTR: begin
        m_phase = P_PWR;
        m_left  = PWRT;
      end
      P_RUN: begin
        if (sleep) begin
          m_phase = P_SLEEP; m_to_n = 1'b1; m_pd_n = 1'b0;
        end else if (clrwdt) begin
          m_wdt = 0; m_to_n = 1'b1; m_pd_n = 1'b1;
        end else if (wdt_en && m_wdt == WDT - 1) begin
          m_phase = P_WDTR; m_to_n = 1'b0; m_cause = 2'b01;
        end else if (wdt_en) begin
          m_wdt++;
        end
      end
      P_SLEEP: begin
        if (wake) begin
          m_phase = P_OSC; m_left = OST; m_woke = 1'b1; m_cause = 2'b11;
        end else if (wdt_en && m_wdt == WDT - 1) begin
          m_phase = P_OSC; m_left = OST; m_woke = 1'b1; m_cause = 2'b10; m_to_n = 1'b0;
        end else if (wdt_en) begin
          m_wdt++;
        end
      end
      default: model_reset();
    endcase
    if (m_phase != prev) m_wdt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_out, model_out());
    clrwdt = 1'b0;
    sleep  = 1'b0;
  endtask

  task automatic add(input int n, input bit en, input bit clr, input bit slp, input bit wk,
                     input logic [5:0] exp, input string name);
    vec_t v;
    v.n = n; v.en = en; v.clr = clr; v.slp = slp; v.wk = wk; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    int rst_left;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    wdt_en = 1'b0;
    clrwdt = 1'b0;
    sleep  = 1'b0;
    wake   = 1'b0;
    model_reset();

    // exp = {core_rst, core_run, to_n, pd_n, rst_cause}
    add(13, 0, 0, 0, 0, 6'b101100, "ost_pwrt_hold");
    add(1,  0, 0, 0, 0, 6'b011100, "run_after_14");
    add(15, 1, 0, 0, 0, 6'b011100, "wdt_pre_expiry");
    add(1,  1, 0, 0, 0, 6'b100101, "wdtrst_1cycle");
    add(1,  1, 0, 0, 0, 6'b100101, "wdt_pwrt_first");
    add(3,  1, 0, 0, 0, 6'b100101, "wdt_pwrt_hold");
    add(1,  1, 0, 0, 0, 6'b010101, "wdt_back_to_run");
    for (int i = 0; i < 10; i++) add(10, 1, 1, 0, 0, 6'b011101, "clrwdt_loop");
    add(1,  1, 0, 1, 0, 6'b001001, "sleep_enter");
    add(4,  1, 0, 0, 0, 6'b001001, "sleep_hold");
    add(1,  1, 0, 0, 1, 6'b001011, "pin_wake_ost");
    add(7,  1, 0, 0, 0, 6'b001011, "pin_wake_ost_hold");
    add(1,  1, 0, 0, 0, 6'b011011, "pin_wake_run");
    add(1,  1, 0, 1, 0, 6'b001011, "sleep2_enter");
    add(15, 1, 0, 0, 0, 6'b001011, "sleep2_pre_expiry");
    add(1,  1, 0, 0, 0, 6'b000010, "wdt_wake_ost");
    add(7,  1, 0, 0, 0, 6'b000010, "wdt_wake_ost_hold");
    add(1,  1, 0, 0, 0, 6'b010010, "wdt_wake_run");
    add(15, 1, 0, 0, 0, 6'b010010, "run_to_limit");
    add(1,  1, 1, 0, 0, 6'b011110, "clrwdt_beats_expiry");
    add(15, 1, 0, 0, 0, 6'b011110, "run_to_limit2");
    add(1,  1, 1, 1, 0, 6'b001010, "sleep_beats_all");
    add(15, 1, 0, 0, 0, 6'b001010, "sleep3_to_limit");
    add(1,  1, 0, 0, 1, 6'b001011, "wake_beats_expiry");
    add(7,  1, 0, 0, 0, 6'b001011, "wake3_ost_hold");
    add(1,  1, 0, 0, 0, 6'b011011, "wake3_run");

    repeat (4) tick();
    chk("reset_state", dut_out, 6'b101100);
    reset = 1'b0;

    foreach (tbl[k]) begin
      wdt_en = tbl[k].en;
      clrwdt = tbl[k].clr;
      sleep  = tbl[k].slp;
      wake   = tbl[k].wk;
      repeat (tbl[k].n) tick();
      chk(tbl[k].name, dut_out, tbl[k].exp);
    end
    wake = 1'b0;

    // Reset asserted mid-SLEEP must act without a clock edge.
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset  = 1'b0;
    wdt_en = 1'b0;
    repeat (14) tick();
    sleep = 1'b1;
    tick();
    repeat (3) tick();
    chk("sleep_before_reset", dut_out, 6'b001000);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_mid_sleep", dut_out, 6'b101100);

    // Reset asserted mid-PWRT after a watchdog reset.
    repeat (2) tick();
    reset  = 1'b0;
    wdt_en = 1'b1;
    repeat (32) tick();
    chk("pwrt_before_reset", dut_out, 6'b100101);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_mid_pwrt", dut_out, 6'b101100);
    tick();
    reset = 1'b0;

    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (reset) begin
        if (rst_left == 0) reset = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset();
        rst_left = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 39) == 0) wdt_en = ~wdt_en;
      clrwdt = ($urandom_range(0, 11) == 0);
      sleep  = ($urandom_range(0, 19) == 0);
      wake   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
